// File: rtl/gfp8_nv_dot_accum_if.sv
// Stream bundle for the group-FP8 dot-product accumulator: vector-pair input
// channel and accumulated-result output channel, each with valid/ready.
interface gfp8_nv_dot_accum_if #(
   parameter int NUM_GROUPS = 4,
   parameter int ACC_W      = 32,
   parameter int CNT_W      = 16
);
   logic                        i_valid;
   logic                        o_ready;
   logic                        i_last;
   logic [8*NUM_GROUPS-1:0]     i_exp_left;
   logic [8*NUM_GROUPS-1:0]     i_exp_right;
   logic [256*NUM_GROUPS-1:0]   i_man_left;
   logic [256*NUM_GROUPS-1:0]   i_man_right;
   logic                        o_valid;
   logic                        i_ready;
   logic signed [ACC_W-1:0]     o_mantissa;
   logic signed [9:0]           o_exponent;
   logic [CNT_W-1:0]            o_count;
   logic                        o_sat;

   modport slave (
      input  i_valid, i_last, i_exp_left, i_exp_right, i_man_left, i_man_right, i_ready,
      output o_ready, o_valid, o_mantissa, o_exponent, o_count, o_sat
   );

   modport master (
      output i_valid, i_last, i_exp_left, i_exp_right, i_man_left, i_man_right, i_ready,
      input  o_ready, o_valid, o_mantissa, o_exponent, o_count, o_sat
   );
endinterface

// File: rtl/gfp8_nv_dot_accum.sv
// Group-FP8 native-vector dot product with chained block-floating accumulation.
// Four stages: capture, per-group dot, group alignment, saturating accumulator.
module gfp8_nv_dot_accum #(
   parameter int NUM_GROUPS = 4,
   parameter int EXP_BIAS   = 15,
   parameter int ACC_W      = 32,
   parameter int CNT_W      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   gfp8_nv_dot_accum_if.slave   bus
);
   typedef enum logic {EMPTY, RUN} state_t;

   // Arithmetic right shift; shifts past the word width flush to zero.
   function automatic logic [ACC_W-1:0] align(input logic [ACC_W-1:0] m, input logic [9:0] sh);
      logic [ACC_W-1:0] r;
      if (sh > 10'(ACC_W - 1)) r = '0;
      else                     r = ACC_W'($signed(m) >>> sh);
      return r;
   endfunction

   logic en;
   logic o_valid_q, o_sat_q;
   logic [ACC_W-1:0] o_man_q;
   logic [9:0]       o_exp_q;
   logic [CNT_W-1:0] o_cnt_q;

   assign en             = !(o_valid_q && !bus.i_ready);
   assign bus.o_ready    = en;
   assign bus.o_valid    = o_valid_q;
   assign bus.o_mantissa = o_man_q;
   assign bus.o_exponent = o_exp_q;
   assign bus.o_count    = o_cnt_q;
   assign bus.o_sat      = o_sat_q;

   // Stage 1: input capture
   logic s1_vld_q, s1_last_q;
   logic [8*NUM_GROUPS-1:0]   s1_el_q, s1_er_q;
   logic [256*NUM_GROUPS-1:0] s1_ml_q, s1_mr_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_el_q   <= '0;
         s1_er_q   <= '0;
         s1_ml_q   <= '0;
         s1_mr_q   <= '0;
      end else if (en) begin
         s1_vld_q <= bus.i_valid;
         if (bus.i_valid) begin
            s1_last_q <= bus.i_last;
            s1_el_q   <= bus.i_exp_left;
            s1_er_q   <= bus.i_exp_right;
            s1_ml_q   <= bus.i_man_left;
            s1_mr_q   <= bus.i_man_right;
         end
      end
   end

   // Stage 2: per-group dot product and unbiased exponent
   logic s2_vld_q, s2_last_q;
   logic [NUM_GROUPS-1:0][ACC_W-1:0] s2_m_d, s2_m_q;
   logic [NUM_GROUPS-1:0][9:0]       s2_e_d, s2_e_q;
   logic signed [ACC_W-1:0] op_a, op_b;

   always_comb begin
      s2_m_d = '0;
      s2_e_d = '0;
      op_a   = '0;
      op_b   = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         for (int e = 0; e < 32; e++) begin
            op_a      = ACC_W'($signed(s1_ml_q[g*256 + e*8 +: 8]));
            op_b      = ACC_W'($signed(s1_mr_q[g*256 + e*8 +: 8]));
            s2_m_d[g] = s2_m_d[g] + op_a * op_b;
         end
         s2_e_d[g] = 10'(s1_el_q[g*8 +: 8]) + 10'(s1_er_q[g*8 +: 8]) - 10'(2 * EXP_BIAS);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_m_q    <= '0;
         s2_e_q    <= '0;
      end else if (en) begin
         s2_vld_q  <= s1_vld_q;
         s2_last_q <= s1_last_q;
         s2_m_q    <= s2_m_d;
         s2_e_q    <= s2_e_d;
      end
   end

   // Stage 3: align groups to the largest exponent and reduce
   logic s3_vld_q, s3_last_q;
   logic [ACC_W-1:0] pm_d, pm_q;
   logic [9:0]       pe_d, pe_q;

   always_comb begin
      pe_d = s2_e_q[0];
      for (int g = 1; g < NUM_GROUPS; g++)
         if ($signed(s2_e_q[g]) > $signed(pe_d)) pe_d = s2_e_q[g];
      pm_d = '0;
      for (int g = 0; g < NUM_GROUPS; g++)
         pm_d = pm_d + align(s2_m_q[g], pe_d - s2_e_q[g]);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s3_vld_q  <= 1'b0;
         s3_last_q <= 1'b0;
         pm_q      <= '0;
         pe_q      <= '0;
      end else if (en) begin
         s3_vld_q  <= s2_vld_q;
         s3_last_q <= s2_last_q;
         pm_q      <= pm_d;
         pe_q      <= pe_d;
      end
   end

   // Stage 4: chain accumulator
   state_t state_q, state_d;
   logic [ACC_W-1:0] acc_m_q, acc_m_d, a_al, p_al;
   logic [9:0]       acc_e_q, acc_e_d, e_max;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             acc_sat_q, acc_sat_d, emit;
   logic [ACC_W:0]   sum_w;

   always_comb begin
      state_d   = state_q;
      acc_m_d   = acc_m_q;
      acc_e_d   = acc_e_q;
      acc_cnt_d = acc_cnt_q;
      acc_sat_d = acc_sat_q;
      emit      = 1'b0;
      e_max     = acc_e_q;
      a_al      = '0;
      p_al      = '0;
      sum_w     = '0;
      if (s3_vld_q) begin
         emit    = s3_last_q;
         state_d = s3_last_q ? EMPTY : RUN;
         case (state_q)
            EMPTY: begin
               acc_m_d   = pm_q;
               acc_e_d   = pe_q;
               acc_cnt_d = CNT_W'(1);
               acc_sat_d = 1'b0;
            end
            RUN: begin
               e_max = ($signed(acc_e_q) > $signed(pe_q)) ? acc_e_q : pe_q;
               a_al  = align(acc_m_q, e_max - acc_e_q);
               p_al  = align(pm_q, e_max - pe_q);
               sum_w = {a_al[ACC_W-1], a_al} + {p_al[ACC_W-1], p_al};
               if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
                  acc_m_d   = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                  acc_sat_d = 1'b1;
               end else begin
                  acc_m_d   = sum_w[ACC_W-1:0];
               end
               acc_e_d   = e_max;
               acc_cnt_d = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= EMPTY;
         acc_m_q   <= '0;
         acc_e_q   <= '0;
         acc_cnt_q <= '0;
         acc_sat_q <= 1'b0;
         o_valid_q <= 1'b0;
         o_man_q   <= '0;
         o_exp_q   <= '0;
         o_cnt_q   <= '0;
         o_sat_q   <= 1'b0;
      end else if (en) begin
         state_q   <= state_d;
         acc_m_q   <= acc_m_d;
         acc_e_q   <= acc_e_d;
         acc_cnt_q <= acc_cnt_d;
         acc_sat_q <= acc_sat_d;
         // en implies any pending result is being taken this edge
         o_valid_q <= emit;
         if (emit) begin
            o_man_q <= acc_m_d;
            o_exp_q <= acc_e_d;
            o_cnt_q <= acc_cnt_d;
            o_sat_q <= acc_sat_d;
         end
      end
   end
endmodule

// File: tb/tb_gfp8_nv_dot_accum.sv
// Bench for gfp8_nv_dot_accum: directed table, latency/backpressure/reset
// sequences and a randomized run scored against an integer reference model.
module tb_gfp8_nv_dot_accum;
   localparam int NG = 4, BIAS = 15, AW = 32, CW = 16;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   typedef struct {
      logic [8*NG-1:0]   el, er;
      logic [256*NG-1:0] ml, mr;
      bit                last;
   } vec_t;
   typedef struct { longint m; int e; int c; bit s; } res_t;
   typedef struct {
      int ml, mr, e0l, e0r, eol, eor;
      bit last, res;
      longint xm; int xe, xc; bit xs;
   } row_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gfp8_nv_dot_accum_if #(.NUM_GROUPS(NG), .ACC_W(AW), .CNT_W(CW)) dif ();

   gfp8_nv_dot_accum #(.NUM_GROUPS(NG), .EXP_BIAS(BIAS), .ACC_W(AW), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(rst), .bus(dif)
   );

   int compared = 0, mismatched = 0;
   int rdy_mode = 0;
   res_t got[$];
   res_t exp_q[$];

   longint m_acc; int m_e, m_cnt; bit m_sat, m_run;

   task automatic chk(input string name, input longint act, input longint req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic longint al(input longint m, input int sh);
      if (sh > AW - 1) return 0;
      return m >>> sh;
   endfunction

   function automatic int sbyte(input logic [256*NG-1:0] m, input int idx);
      logic [7:0] b;
      b = m[idx*8 +: 8];
      return int'($signed(b));
   endfunction

   // Reference: exact integer dot per group, then block-float alignment and chaining
   function automatic void model_push(input vec_t v);
      longint gm[NG]; int ge[NG];
      logic [7:0] xl, xr;
      int mx, big_e; longint pm, s;
      for (int g = 0; g < NG; g++) begin
         gm[g] = 0;
         for (int e = 0; e < 32; e++)
            gm[g] += longint'(sbyte(v.ml, g*32 + e) * sbyte(v.mr, g*32 + e));
         xl = v.el[g*8 +: 8];
         xr = v.er[g*8 +: 8];
         ge[g] = int'(xl) + int'(xr) - 2*BIAS;
      end
      mx = ge[0];
      for (int g = 1; g < NG; g++) if (ge[g] > mx) mx = ge[g];
      pm = 0;
      for (int g = 0; g < NG; g++) pm += al(gm[g], mx - ge[g]);
      if (!m_run) begin
         m_acc = pm; m_e = mx; m_cnt = 1; m_sat = 0;
      end else begin
         big_e = (m_e > mx) ? m_e : mx;
         s = al(m_acc, big_e - m_e) + al(pm, big_e - mx);
         if (s > MAXV) begin s = MAXV; m_sat = 1; end
         else if (s < MINV) begin s = MINV; m_sat = 1; end
         m_acc = s; m_e = big_e;
         if (m_cnt < 65535) m_cnt++;
      end
      if (v.last) begin
         exp_q.push_back('{m_acc, m_e, m_cnt, m_sat});
         m_run = 0;
      end else m_run = 1;
   endfunction

   function automatic vec_t mkvec(input int ml, input int mr, input int e0l, input int e0r,
                                  input int eol, input int eor, input bit last);
      vec_t v;
      for (int i = 0; i < 32*NG; i++) begin
         v.ml[i*8 +: 8] = 8'(ml);
         v.mr[i*8 +: 8] = 8'(mr);
      end
      for (int g = 0; g < NG; g++) begin
         v.el[g*8 +: 8] = 8'((g == 0) ? e0l : eol);
         v.er[g*8 +: 8] = 8'((g == 0) ? e0r : eor);
      end
      v.last = last;
      return v;
   endfunction

   function automatic vec_t rndvec(input bit last);
      vec_t v;
      for (int i = 0; i < 8*NG; i++) begin
         v.ml[i*32 +: 32] = $urandom();
         v.mr[i*32 +: 32] = $urandom();
      end
      for (int g = 0; g < NG; g++) begin
         v.el[g*8 +: 8] = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(12, 18));
         v.er[g*8 +: 8] = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(12, 18));
      end
      v.last = last;
      return v;
   endfunction

   // Drives one vector, returns just after its transfer edge with i_valid dropped
   task automatic send(input vec_t v);
      int guard = 0;
      @(negedge clk);
      dif.i_valid = 1'b1; dif.i_last = v.last;
      dif.i_exp_left = v.el; dif.i_exp_right = v.er;
      dif.i_man_left = v.ml; dif.i_man_right = v.mr;
      #1;
      while (!dif.o_ready && guard < 2000) begin
         @(negedge clk); #1; guard++;
      end
      if (!dif.o_ready) begin
         chk("send_timeout", 0, 1);
      end else begin
         model_push(v);
         @(posedge clk);
      end
      #1 dif.i_valid = 1'b0;
   endtask

   task automatic wait_res(input string name, input longint xm, input int xe, input int xc, input bit xs);
      int guard = 0;
      res_t r;
      while (got.size() == 0 && guard < 64) begin
         @(negedge clk); #3; guard++;
      end
      if (got.size() == 0) begin
         chk({name, "_timeout"}, 0, 1);
      end else begin
         r = got.pop_front();
         chk({name, "_mant"}, r.m, xm);
         chk({name, "_exp"}, r.e, xe);
         chk({name, "_cnt"}, r.c, xc);
         chk({name, "_sat"}, r.s, xs);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst = 1'b1; dif.i_valid = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      got.delete(); exp_q.delete(); m_run = 0;
   endtask

   // Sink/monitor: picks i_ready, checks hold and ready rules, collects results
   bit hold_prev = 0;
   res_t hold_v;
   always @(negedge clk) begin
      case (rdy_mode)
         0:       dif.i_ready = 1'b1;
         1:       dif.i_ready = 1'($urandom_range(0, 1));
         default: dif.i_ready = 1'b0;
      endcase
      #2;
      if (rst !== 1'b0) hold_prev = 0;
      else begin
         if (hold_prev) begin
            chk("hold_valid", dif.o_valid, 1);
            chk("hold_mant", dif.o_mantissa, hold_v.m);
            chk("hold_exp", dif.o_exponent, hold_v.e);
            chk("hold_cnt", dif.o_count, hold_v.c);
            chk("hold_sat", dif.o_sat, hold_v.s);
         end
         chk("o_ready", dif.o_ready, !(dif.o_valid && !dif.i_ready));
         hold_v = '{longint'(dif.o_mantissa), int'(dif.o_exponent), int'(dif.o_count), dif.o_sat};
         if (dif.o_valid && dif.i_ready) got.push_back(hold_v);
         hold_prev = dif.o_valid && !dif.i_ready;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   row_t tbl[14];
   initial begin
      vec_t v;
      int n;
      tbl[0]  = '{1, 1, 15, 15, 15, 15, 1'b1, 1'b1, 128, 0, 1, 1'b0};
      tbl[1]  = '{1, 1, 16, 16, 15, 15, 1'b1, 1'b1, 56, 2, 1, 1'b0};
      tbl[2]  = '{1, 1, 35, 35, 15, 15, 1'b1, 1'b1, 32, 40, 1, 1'b0};
      tbl[3]  = '{-1, 1, 15, 15, 15, 15, 1'b1, 1'b1, -128, 0, 1, 1'b0};
      tbl[4]  = '{2, 3, 0, 0, 0, 0, 1'b1, 1'b1, 768, -30, 1, 1'b0};
      tbl[5]  = '{1, 1, 255, 255, 255, 255, 1'b1, 1'b1, 128, 480, 1, 1'b0};
      tbl[6]  = '{1, 1, 0, 0, 15, 15, 1'b1, 1'b1, 96, 0, 1, 1'b0};
      tbl[7]  = '{-1, 1, 0, 0, 16, 15, 1'b1, 1'b1, -97, 1, 1, 1'b0};
      tbl[8]  = '{-1, 1, 0, 0, 17, 15, 1'b1, 1'b1, -96, 2, 1, 1'b0};
      tbl[9]  = '{-128, -128, 15, 15, 15, 15, 1'b1, 1'b1, 2097152, 0, 1, 1'b0};
      tbl[10] = '{127, -128, 15, 15, 15, 15, 1'b1, 1'b1, -2080768, 0, 1, 1'b0};
      tbl[11] = '{1, 1, 15, 15, 15, 15, 1'b0, 1'b0, 0, 0, 0, 1'b0};
      tbl[12] = '{1, 1, 15, 15, 15, 15, 1'b0, 1'b0, 0, 0, 0, 1'b0};
      tbl[13] = '{1, 1, 15, 15, 15, 15, 1'b1, 1'b1, 384, 0, 3, 1'b0};

      rst = 1'b1; m_run = 0;
      dif.i_valid = 1'b0; dif.i_last = 1'b0; dif.i_ready = 1'b1;
      dif.i_exp_left = '0; dif.i_exp_right = '0; dif.i_man_left = '0; dif.i_man_right = '0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;

      @(negedge clk); #3;
      chk("rst_valid", dif.o_valid, 0);
      chk("rst_mant", dif.o_mantissa, 0);
      chk("rst_exp", dif.o_exponent, 0);
      chk("rst_cnt", dif.o_count, 0);
      chk("rst_sat", dif.o_sat, 0);
      chk("rst_ready", dif.o_ready, 1);

      // Latency: result visible exactly four cycles after the transfer cycle
      send(mkvec(1, 1, 15, 15, 15, 15, 1'b1));
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); #3;
         chk($sformatf("lat_valid_c%0d", k), dif.o_valid, (k == 4));
      end
      wait_res("lat", 128, 0, 1, 0);

      // Directed table, back-to-back within the chain rows
      for (int r = 0; r < 14; r++) begin
         send(mkvec(tbl[r].ml, tbl[r].mr, tbl[r].e0l, tbl[r].e0r, tbl[r].eol, tbl[r].eor, tbl[r].last));
         if (tbl[r].res) wait_res($sformatf("row%0d", r), tbl[r].xm, tbl[r].xe, tbl[r].xc, tbl[r].xs);
      end

      // Positive saturation over a 1024-vector chain
      for (int i = 0; i < 1024; i++) send(mkvec(-128, -128, 15, 15, 15, 15, i == 1023));
      wait_res("sat", 64'h7FFFFFFF, 0, 1024, 1);

      // Backpressure: result held, input stalls, queued chain completes afterwards
      rdy_mode = 2;
      send(mkvec(1, 1, 15, 15, 15, 15, 1'b1));
      fork
         begin
            send(mkvec(1, 1, 15, 15, 15, 15, 1'b0));
            send(mkvec(1, 1, 15, 15, 15, 15, 1'b1));
         end
         begin
            repeat (12) @(negedge clk);
            #3;
            chk("bp_valid", dif.o_valid, 1);
            chk("bp_ready", dif.o_ready, 0);
            rdy_mode = 0;
         end
      join
      wait_res("bp_first", 128, 0, 1, 0);
      wait_res("bp_second", 256, 0, 2, 0);

      // Reset mid-chain discards it
      send(mkvec(1, 1, 15, 15, 15, 15, 1'b0));
      send(mkvec(1, 1, 15, 15, 15, 15, 1'b0));
      do_reset();
      send(mkvec(1, 1, 15, 15, 15, 15, 1'b1));
      wait_res("post_rst", 128, 0, 1, 0);
      repeat (10) @(negedge clk);
      #3 chk("post_rst_extra", got.size(), 0);

      // Randomized chains with random backpressure and gaps
      got.delete(); exp_q.delete();
      rdy_mode = 1;
      for (int c = 0; c < 80; c++) begin
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) begin
            send(rndvec(k == n - 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      for (int g = 0; g < 400 && got.size() < exp_q.size(); g++) @(negedge clk);
      #3 chk("rand_count", got.size(), exp_q.size());
      while (got.size() > 0 && exp_q.size() > 0) begin
         res_t a, b;
         a = got.pop_front(); b = exp_q.pop_front();
         chk("rand_mant", a.m, b.m);
         chk("rand_exp", a.e, b.e);
         chk("rand_cnt", a.c, b.c);
         chk("rand_sat", a.s, b.s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/gfp8_nv_dot_accum.md
GFP8_NV_DOT_ACCUM -- requirements
Module: gfp8_nv_dot_accum

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 4; number of 32-element groups per native vector.
REQ-002 SHALL have parameter EXP_BIAS, default 15; per-operand exponent bias.
REQ-003 SHALL have parameter ACC_W, default 32; mantissa accumulator and output width.
REQ-004 SHALL have parameter CNT_W, default 16; vector-count width.
REQ-005 SHALL have port i_clk, input, 1; single clock, all logic on rising edge.
REQ-006 SHALL have port i_reset, input, 1; synchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1; input vector pair valid.
REQ-008 SHALL have port o_ready, output, 1; block accepts input this cycle.
REQ-009 SHALL have port i_last, input, 1; qualifies the final vector of an accumulation chain.
REQ-010 SHALL have port i_exp_left, input, 8*NUM_GROUPS; unsigned group exponents, byte g = group g.
REQ-011 SHALL have port i_man_left, input, 256*NUM_GROUPS; signed int8 mantissas, element e of group g at bits [g*256+e*8 +: 8].
REQ-012 SHALL have ports i_exp_right and i_man_right, input, same widths and packing as the left ports.
REQ-013 SHALL have port o_valid, output, 1; result valid.
REQ-014 SHALL have port i_ready, input, 1; downstream accepts result.
REQ-015 SHALL have port o_mantissa, output, ACC_W signed; accumulated mantissa.
REQ-016 SHALL have port o_exponent, output, 10 signed; result exponent.
REQ-017 SHALL have port o_count, output, CNT_W; vectors in the chain, saturating at all-ones.
REQ-018 SHALL have port o_sat, output, 1; set if any accumulation in the chain saturated.

Function
REQ-019 Handshake: input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
REQ-020 Stall: en = !(o_valid && !i_ready); o_ready = en; all pipeline and accumulator registers hold when en=0.
REQ-021 Stage 1: capture inputs, i_last and a valid bit on transfer; a bubble advances with valid=0.
REQ-022 Stage 2: register per group g the sum of 32 signed 8x8 products, sign-extended to ACC_W, and exponent eL+eR-2*EXP_BIAS in 10-bit signed.
REQ-023 Stage 3: max exponent over groups; each group mantissa arithmetic-right-shifted by (max - own exponent), zero if the shift exceeds ACC_W-1; register the sum as partial (pm, pe).
REQ-024 Stage 4 SHALL be the accumulator with states EMPTY and RUN; reset state is EMPTY.
REQ-025 EMPTY with a valid partial: acc=(pm,pe), count=1, sat=0; go to RUN, or emit and stay EMPTY if last.
REQ-026 RUN with a valid partial: E=max(acc_exp,pe); align both by the REQ-023 shift rule; ACC_W+1-bit sum saturated to signed ACC_W range; sat |= saturated; count+1 saturating; go to EMPTY and emit if last.
REQ-027 Emit loads o_mantissa, o_exponent, o_count and o_sat from the new accumulated values and sets o_valid=1 on the same edge.
REQ-028 An output transfer without a new emit clears o_valid; a transfer and an emit on the same edge keep o_valid=1 with the new data.
REQ-029 Outputs SHALL hold stable while o_valid && !i_ready.
REQ-030 Latency: a last vector transferred in cycle T gives o_valid in cycle T+4 when no stall occurs; throughput is one vector per cycle.
REQ-031 Exponent arithmetic SHALL be 10-bit signed and never wrap for 8-bit inputs.

Reset
REQ-032 i_reset=1 SHALL clear all valid bits and the accumulator on the next edge and force state EMPTY.
REQ-033 Reset values: o_valid=0, o_mantissa=0, o_exponent=0, o_count=0, o_sat=0; o_ready=1 in the first cycle after reset.
REQ-034 Reset mid-chain or while a result is pending SHALL discard the partial chain; no result is emitted for it.

Verification
REQ-035 Single vector: all mantissas 1, all exponents 15, last=1 -> o_mantissa=128, o_exponent=0, o_count=1, o_sat=0, 4 cycles after transfer.
REQ-036 Chain: three back-to-back copies of REQ-035 vector, last on third -> one result, 384, exponent 0, count 3.
REQ-037 Alignment: group0 exponents 16/16, other groups 15/15, mantissas 1, last=1 -> 56, exponent 2; group0 exponents 35/35, others 15/15 -> 32, exponent 40.
REQ-038 Saturation: 1024 vectors, all mantissas -128, exponents 15, last on 1024th -> o_mantissa=0x7FFFFFFF, o_sat=1, count=1024.
REQ-039 Backpressure: i_ready=0 while a result is pending -> o_ready=0, outputs stable; streamed chains resume without loss after i_ready=1.
REQ-040 Reset after 2 of 3 chain vectors, then a fresh single vector -> only the fresh result appears, count=1.
